// File: rtl/simplerisc_pkg.sv
// SimpleRISC shared decode: opcodes, IR field layout, immediate forms and source-read predicates
// used by the OF/EX latch and the forwarding units.
package simplerisc_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [4:0] OP_CMP  = 5'b00101;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_MOV  = 5'b01001;
    localparam logic [4:0] OP_NOP  = 5'b01101;
    localparam logic [4:0] OP_LD   = 5'b01110;
    localparam logic [4:0] OP_ST   = 5'b01111;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BGT  = 5'b10001;
    localparam logic [4:0] OP_B    = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;

    localparam logic [3:0]  RA_IDX = 4'hF;
    localparam logic [31:0] NOP_IR = 32'h6800_0000;

    localparam logic [1:0] IMM_SEXT = 2'b00;
    localparam logic [1:0] IMM_ZEXT = 2'b01;
    localparam logic [1:0] IMM_HI   = 2'b10;

    typedef struct packed {
        logic [4:0]  opcode;
        logic        i_bit;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [13:0] low;
    } ir_t;

    function automatic logic reads_src1(input logic [4:0] op);
        return !(op inside {OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_NOT, OP_MOV});
    endfunction

    function automatic logic reads_src2(input ir_t ir);
        return !ir.i_bit || (ir.opcode == OP_ST);
    endfunction

    function automatic logic [3:0] src1_idx(input ir_t ir);
        return (ir.opcode == OP_RET) ? RA_IDX : ir.rs1;
    endfunction

    // Stores read their data register through the rd field.
    function automatic logic [3:0] src2_idx(input ir_t ir);
        return (ir.opcode == OP_ST) ? ir.rd : ir.rs2;
    endfunction

    function automatic logic [31:0] imm_ext(input logic [31:0] ir);
        logic [31:0] v;
        case (ir[17:16])
            IMM_ZEXT: v = {16'h0000, ir[15:0]};
            IMM_HI:   v = {ir[15:0], 16'h0000};
            default:  v = {{16{ir[15]}}, ir[15:0]};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/of_ex_latch_if.sv
// OF->EX pipeline boundary: OF-side operands/flags in, EX-side latched payload and stall out.
interface of_ex_latch_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] of_ir;
    logic [XLEN-1:0] of_pc;
    logic [XLEN-1:0] rf_op1;
    logic [XLEN-1:0] rf_op2;
    logic            fwd_rw_of_src1;
    logic            fwd_rw_of_src2;
    logic [XLEN-1:0] rw_result;
    logic            branch_taken;
    logic            stall_o;
    logic [XLEN-1:0] ex_ir;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic [XLEN-1:0] ex_op2;
    logic            ex_valid;

    modport master (
        output of_ir, of_pc, rf_op1, rf_op2, fwd_rw_of_src1, fwd_rw_of_src2,
               rw_result, branch_taken,
        input  stall_o, ex_ir, ex_pc, ex_a, ex_b, ex_op2, ex_valid
    );

    modport slave (
        input  of_ir, of_pc, rf_op1, rf_op2, fwd_rw_of_src1, fwd_rw_of_src2,
               rw_result, branch_taken,
        output stall_o, ex_ir, ex_pc, ex_a, ex_b, ex_op2, ex_valid
    );
endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard: a valid ld in EX whose rd is a source register the OF instruction actually reads.
module load_use_detect
    import simplerisc_pkg::*;
(
    input  logic [31:0] ex_ir,
    input  logic        ex_valid,
    input  logic [31:0] of_ir,
    output logic        hazard
);
    ir_t  w_ex;
    ir_t  w_of;
    logic w_hit1;
    logic w_hit2;

    assign w_ex = ir_t'(ex_ir);
    assign w_of = ir_t'(of_ir);

    assign w_hit1 = reads_src1(w_of.opcode) && (src1_idx(w_of) == w_ex.rd);
    assign w_hit2 = reads_src2(w_of) && (src2_idx(w_of) == w_ex.rd);

    assign hazard = ex_valid && (w_ex.opcode == OP_LD) && (w_hit1 || w_hit2);

    wire w_unused_ok = &{1'b0, w_ex.i_bit, w_ex.rs1, w_ex.rs2, w_ex.low, w_of.low};
endmodule

// File: rtl/of_ex_latch.sv
// OF/EX pipeline register with RW->OF operand forwarding, load-use stall and branch flush.
// Optional saturating stall/flush counters when OF_EX_PERF_CNT_EN is defined.
module of_ex_latch #(
    parameter int unsigned      XLEN   = simplerisc_pkg::XLEN,
    parameter logic [XLEN-1:0] NOP_IR = XLEN'(simplerisc_pkg::NOP_IR)
) (
    input  logic        clk,
    input  logic        rst_n,
    of_ex_latch_if.slave bus
`ifdef OF_EX_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);
    import simplerisc_pkg::*;

    logic            w_hazard;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op2_raw;
    logic [XLEN-1:0] w_imm;

    logic [XLEN-1:0] w_nxt_ir, w_nxt_pc, w_nxt_a, w_nxt_b, w_nxt_op2;
    logic            w_nxt_valid;

    logic [XLEN-1:0] r_ex_ir, r_ex_pc, r_ex_a, r_ex_b, r_ex_op2;
    logic            r_ex_valid;

    load_use_detect u_lud (
        .ex_ir    (32'(r_ex_ir)),
        .ex_valid (r_ex_valid),
        .of_ir    (32'(bus.of_ir)),
        .hazard   (w_hazard)
    );

    assign w_op_a    = bus.fwd_rw_of_src1 ? bus.rw_result : bus.rf_op1;
    assign w_op2_raw = bus.fwd_rw_of_src2 ? bus.rw_result : bus.rf_op2;
    assign w_imm     = XLEN'(imm_ext(32'(bus.of_ir)));

    // A taken branch flushes OF, so it must not also freeze the front end.
    assign bus.stall_o = w_hazard && !bus.branch_taken;

    always_comb begin
        w_nxt_ir    = NOP_IR;
        w_nxt_pc    = '0;
        w_nxt_a     = '0;
        w_nxt_b     = '0;
        w_nxt_op2   = '0;
        w_nxt_valid = 1'b0;
        if (!bus.branch_taken && !w_hazard) begin
            w_nxt_ir    = bus.of_ir;
            w_nxt_pc    = bus.of_pc;
            w_nxt_a     = w_op_a;
            w_nxt_b     = bus.of_ir[26] ? w_imm : w_op2_raw;
            w_nxt_op2   = w_op2_raw;
            w_nxt_valid = (bus.of_ir != NOP_IR);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_ir    <= NOP_IR;
            r_ex_pc    <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_ex_op2   <= '0;
            r_ex_valid <= 1'b0;
        end else begin
            r_ex_ir    <= w_nxt_ir;
            r_ex_pc    <= w_nxt_pc;
            r_ex_a     <= w_nxt_a;
            r_ex_b     <= w_nxt_b;
            r_ex_op2   <= w_nxt_op2;
            r_ex_valid <= w_nxt_valid;
        end
    end

    assign bus.ex_ir    = r_ex_ir;
    assign bus.ex_pc    = r_ex_pc;
    assign bus.ex_a     = r_ex_a;
    assign bus.ex_b     = r_ex_b;
    assign bus.ex_op2   = r_ex_op2;
    assign bus.ex_valid = r_ex_valid;

`ifdef OF_EX_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (bus.stall_o && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (bus.branch_taken && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif
endmodule

// File: doc/of_ex_latch.md
Name: of_ex_latch

Overview:
- Pipeline register between Operand Fetch (OF) and Execute (EX) of the 5-stage SimpleRISC pipeline.
- Consumes the RW->OF forwarding flags from the src1/src2 forwarding units and builds final A/B/store operands.
- Detects load-use hazards, stalls IF/OF, and injects bubbles.
- Squashes the OF instruction on a taken branch.

Parameters:
- XLEN, 32, datapath and IR width
- NOP_IR, 32'h6800_0000, bubble instruction (opcode 01101)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- of_ir  in  XLEN  instruction in OF
- of_pc  in  XLEN  PC of OF instruction
- rf_op1  in  XLEN  register-file read, port 1
- rf_op2  in  XLEN  register-file read, port 2
- fwd_rw_of_src1  in  1  RW->OF conflict on src1
- fwd_rw_of_src2  in  1  RW->OF conflict on src2
- rw_result  in  XLEN  value being written back by RW
- branch_taken  in  1  EX resolved a taken branch this cycle
- stall_o  out  1  hold PC and IF/OF register
- ex_ir  out  XLEN  latched IR for EX
- ex_pc  out  XLEN  latched PC
- ex_a  out  XLEN  operand A
- ex_b  out  XLEN  operand B (register or immediate)
- ex_op2  out  XLEN  store data / raw src2
- ex_valid  out  1  1 = real instruction, 0 = bubble

Behaviour:
- Reset (rst_n=0 at posedge): ex_ir=NOP_IR, ex_pc/ex_a/ex_b/ex_op2=0, ex_valid=0.
- Field decode on of_ir:
  - opcode [31:27], I-bit [26], rd [25:22], rs1 [21:18], rs2 [17:14].
  - Immediate modifier [17:16] selects the immediate form: 00 sign-extends imm[15:0]; 01 zero-extends it; 10 places imm[15:0] in [31:16] with zeros below; 11 is treated as 00.
- Source register selection:
  - ret (10100): src1 = ra (4'hF).
  - st (01111): the store-data register is rd.
- Operand A = fwd_rw_of_src1 ? rw_result : rf_op1.
- op2 raw = fwd_rw_of_src2 ? rw_result : rf_op2.
- ex_b = I ? immediate : op2 raw; ex_op2 = op2 raw.
- Load-use hazard (combinational, same cycle):
  - Condition: the latched ex_ir is ld (01110), ex_valid=1, and its rd equals an OF source actually read by the OF opcode.
  - src1 is read by all opcodes except nop, b, beq, bgt, call, not, mov.
  - src2 is read when I=0, and also for st via rd.
  - Result: stall_o=1.
- Next-state priority, evaluated at each posedge with rst_n=1:
  1. branch_taken: load NOP_IR, ex_valid=0, stall_o forced 0 (flush overrides stall).
  2. stall_o: load NOP_IR, ex_valid=0; the OF instruction is held upstream.
  3. Otherwise: latch of_ir/of_pc/operands, ex_valid=1.
- Latency: one cycle OF->EX.
- A load-use stall lasts exactly one cycle: next cycle the ld is in MA, EX holds a bubble, and the hazard deasserts.
- An incoming of_ir == NOP_IR latches with ex_valid=0.
- Reset mid-stall discards held state; stall_o=0 the following cycle.

Optional Feature:
- Macro OF_EX_PERF_CNT_EN.
- When defined, adds outputs stall_cnt[31:0] and flush_cnt[31:0]:
  - stall_cnt increments on each cycle with stall_o=1 and branch_taken=0.
  - flush_cnt increments on each cycle with branch_taken=1.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined: no counters and no ports; behaviour is otherwise identical.

Decomposition:
- Package simplerisc_pkg:
  - opcode localparams (OP_NOP, OP_LD, OP_ST, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_RET, OP_MOV, OP_NOT, OP_CMP);
  - RA_IDX=4'hF; NOP_IR;
  - immediate-modifier constants.
- Sub-module load_use_detect: combinational; inputs ex_ir, ex_valid, of_ir; output hazard.
- Shares the opcode predicates with the forwarding units.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> ex_ir=32'h6800_0000, ex_valid=0, stall_o=0.
- Forwarding:
  - Stimulus: of_ir=add r1,r2,r3 (I=0); rf_op1=5; rf_op2=7; fwd_rw_of_src1=1; rw_result=9.
  - Expected next cycle: ex_a=9, ex_b=7, ex_valid=1.
- Immediates with of_ir=addi and I=1:
  - imm=16'hFFFE, mod=00 -> ex_b=32'hFFFF_FFFE.
  - mod=01 -> ex_b=32'h0000_FFFE.
  - mod=10 -> ex_b=32'hFFFE_0000.
- Load-use:
  - Stimulus: ld r4 latched in EX; OF=add r5,r4,r6.
  - Expected: stall_o=1 for exactly 1 cycle and a bubble in EX; the add latches on the following cycle.
- Flush vs stall: load-use condition and branch_taken=1 in the same cycle -> stall_o=0, ex_ir=NOP_IR, ex_valid=0.
- st operand: OF=st r7,[r2+4], rf_op2=r7 value 42 -> ex_op2=42, ex_b=4. With OF_EX_PERF_CNT_EN defined, 3 stalls -> stall_cnt=3.
